// File: rtl/sparc_rf_pkg.sv
// Shared constants and logical-to-physical register index mapping for the
// SPARC windowed register file.
package sparc_rf_pkg;

    localparam int unsigned NGLOBALS  = 32'd8;
    localparam int unsigned WIN_REGS  = 32'd16;
    localparam int unsigned LOCAL_OFS = 32'd0;
    localparam int unsigned IN_OFS    = 32'd8;

    // Outs of window c are physically the ins of window c-1, so r8..15 map there.
    function automatic int unsigned phys_idx(
        input logic [4:0]  addr,
        input int unsigned cwp,
        input int unsigned nwin
    );
        int unsigned reg_ofs_s;
        int unsigned idx_s;
        reg_ofs_s = {29'd0, addr[2:0]};
        case (addr[4:3])
            2'd0:    idx_s = reg_ofs_s;
            2'd1:    idx_s = NGLOBALS + WIN_REGS * ((cwp + nwin - 32'd1) % nwin) + IN_OFS + reg_ofs_s;
            2'd2:    idx_s = NGLOBALS + WIN_REGS * cwp + LOCAL_OFS + reg_ofs_s;
            2'd3:    idx_s = NGLOBALS + WIN_REGS * cwp + IN_OFS + reg_ofs_s;
            default: idx_s = 32'd0;
        endcase
        return idx_s;
    endfunction

endpackage

// File: rtl/window_addr_map.sv
// Combinational map from a 5-bit logical register address and the current
// window pointer to a physical register-array index.
module window_addr_map
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = $clog2(NWINDOWS),
    parameter int PHYS_W   = $clog2(NGLOBALS + WIN_REGS * NWINDOWS)
) (
    input  logic [4:0]        addr,
    input  logic [CWP_W-1:0]  cwp,
    output logic [PHYS_W-1:0] phys
);

    assign phys = PHYS_W'(phys_idx(addr, 32'(cwp), NWINDOWS));

endmodule

// File: rtl/sparc_window_regfile.sv
// Parametrised SPARC windowed register file: two combinational read ports,
// one registered write port, CWP with SAVE/RESTORE and WIM trap detection.
module sparc_window_regfile
    import sparc_rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          RdA,
    input  logic [4:0]          RdB,
    output logic [DATA_W-1:0]   PortA,
    output logic [DATA_W-1:0]   PortB,
    input  logic                Wr_En,
    input  logic [4:0]          WrAddr,
    input  logic [DATA_W-1:0]   WrData,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CWP_Ld,
    input  logic [CWP_W-1:0]    CWP_In,
    input  logic [NWINDOWS-1:0] WIM,
    output logic [CWP_W-1:0]    CWP,
    output logic                Ovf_Trap,
    output logic                Unf_Trap
);

    localparam int NPHYS  = NGLOBALS + WIN_REGS * NWINDOWS;
    localparam int PHYS_W = $clog2(NPHYS);

    logic [DATA_W-1:0] regs_r [NPHYS];
    logic [CWP_W-1:0]  cwp_r;
    logic              ovf_trap_r;
    logic              unf_trap_r;
    logic [PHYS_W-1:0] a_idx_s;
    logic [PHYS_W-1:0] b_idx_s;
    logic [PHYS_W-1:0] w_idx_s;
    logic [CWP_W-1:0]  save_next_s;
    logic [CWP_W-1:0]  restore_next_s;
    logic [CWP_W-1:0]  ld_val_s;

    window_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_a (
        .addr (RdA),
        .cwp  (cwp_r),
        .phys (a_idx_s)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_b (
        .addr (RdB),
        .cwp  (cwp_r),
        .phys (b_idx_s)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_w (
        .addr (WrAddr),
        .cwp  (cwp_r),
        .phys (w_idx_s)
    );

    // Neighbouring window pointers with explicit wrap for non-power-of-two window counts.
    always_comb begin
        save_next_s    = cwp_r - CWP_W'(1);
        restore_next_s = cwp_r + CWP_W'(1);
        if (cwp_r == CWP_W'(0)) begin
            save_next_s = CWP_W'(NWINDOWS - 1);
        end else begin
            save_next_s = cwp_r - CWP_W'(1);
        end
        if (cwp_r == CWP_W'(NWINDOWS - 1)) begin
            restore_next_s = CWP_W'(0);
        end else begin
            restore_next_s = cwp_r + CWP_W'(1);
        end
    end

    assign ld_val_s = CWP_W'(32'(CWP_In) % NWINDOWS);

    // Register array: synchronous clear of every word, otherwise write into the pre-edge window.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NPHYS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (Wr_En && (WrAddr != 5'd0)) begin
            regs_r[w_idx_s] <= WrData;
        end
    end

    // Window pointer and trap pulses; a trapping request leaves CWP untouched.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cwp_r      <= '0;
            ovf_trap_r <= 1'b0;
            unf_trap_r <= 1'b0;
        end else begin
            ovf_trap_r <= 1'b0;
            unf_trap_r <= 1'b0;
            if (CWP_Ld) begin
                cwp_r <= ld_val_s;
            end else if (Save && !Restore) begin
                if (WIM[save_next_s]) begin
                    ovf_trap_r <= 1'b1;
                end else begin
                    cwp_r <= save_next_s;
                end
            end else if (Restore && !Save) begin
                if (WIM[restore_next_s]) begin
                    unf_trap_r <= 1'b1;
                end else begin
                    cwp_r <= restore_next_s;
                end
            end else begin
                cwp_r <= cwp_r;
            end
        end
    end

    assign PortA    = (RdA == 5'd0) ? '0 : regs_r[a_idx_s];
    assign PortB    = (RdB == 5'd0) ? '0 : regs_r[b_idx_s];
    assign CWP      = cwp_r;
    assign Ovf_Trap = ovf_trap_r;
    assign Unf_Trap = unf_trap_r;

endmodule
